// File: rtl/mvau_weight_fetch.sv
// mvau_weight_fetch: per-PE weight streaming stage.
// Issues weight memory read addresses in order 0..WMEM_DEPTH-1 (wrapping),
// captures the returned SIMD*TW-bit word and presents it on a valid/ready
// stream. Addresses advance only when a read is issued, so backpressure never
// drops or duplicates a word.
//
// Optional feature macro: MVAU_WMEM_REG_RD_EN
//   undefined : combinational memory read, single output register
//   defined   : registered memory read (data one cycle after address), one
//               in-flight read tracked, 2-entry FIFO drives the stream
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   en         enable issuing new reads
//   wmem_addr  weight memory read address
//   wmem_in    weight memory read data
//   out_wgt    weight word to compute datapath
//   out_v      out_wgt valid
//   out_rdy    downstream accepts out_wgt
//   out_last   word came from address WMEM_DEPTH-1
module mvau_weight_fetch #(
    parameter int unsigned SIMD         = 2,
    parameter int unsigned TW           = 1,
    parameter int unsigned WMEM_DEPTH   = 4,
    parameter int unsigned WMEM_ADDR_BW = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic [WMEM_ADDR_BW-1:0]   wmem_addr,
    input  logic [SIMD*TW-1:0]        wmem_in,
    output logic [SIMD*TW-1:0]        out_wgt,
    output logic                      out_v,
    input  logic                      out_rdy,
    output logic                      out_last
);

    localparam int unsigned DW = SIMD * TW;
    localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    logic [WMEM_ADDR_BW-1:0] rd_addr;
    logic                    issue_c;
    logic                    at_last_c;
    logic                    take_c;

    assign at_last_c = (rd_addr == LAST_ADDR);
    assign take_c    = out_v && out_rdy;
    assign wmem_addr = rd_addr;

    // Read pointer: advances once per issued read, wraps after the last word
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr <= '0;
        end else if (issue_c) begin
            rd_addr <= at_last_c ? '0 : rd_addr + WMEM_ADDR_BW'(1);
        end
    end

`ifdef MVAU_WMEM_REG_RD_EN

    logic          inflight;
    logic          inflight_last;
    logic [1:0]    count;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [DW-1:0] fifo_wgt [2];
    logic [1:0]    fifo_last;
    logic          push_c;

    // Issue only if the FIFO can still absorb this read once it returns,
    // counting the read already in flight and the word leaving this cycle.
    assign push_c  = inflight;
    assign issue_c = en && ((3'(count) + 3'(inflight) - 3'(take_c)) < 3'd2);

    // In-flight tracker and 2-entry FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            count         <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_last     <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_wgt[i] <= '0;
            end
        end else begin
            inflight <= issue_c;
            if (issue_c) begin
                inflight_last <= at_last_c;
            end
            if (push_c) begin
                fifo_wgt[wr_ptr]  <= wmem_in;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (take_c) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push_c) - 2'(take_c);
        end
    end

    assign out_v    = (count != 2'd0);
    assign out_wgt  = fifo_wgt[rd_ptr];
    assign out_last = fifo_last[rd_ptr];

`else

    // Load whenever the output register is empty or being drained this cycle
    assign issue_c = en && (!out_v || out_rdy);

    // Single output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_wgt  <= '0;
            out_v    <= 1'b0;
            out_last <= 1'b0;
        end else if (issue_c) begin
            out_wgt  <= wmem_in;
            out_v    <= 1'b1;
            out_last <= at_last_c;
        end else if (take_c) begin
            out_v <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_mvau_weight_fetch.sv
// Testbench for mvau_weight_fetch: a depth-4 instance driven with directed
// scenarios and a depth-1 instance running alongside. A scoreboard tracks the
// next expected address of the accepted stream and checks every transfer and
// every stalled cycle.
module tb_mvau_weight_fetch;

    localparam int unsigned SIMD  = 4;
    localparam int unsigned TW    = 2;
    localparam int unsigned DW    = SIMD * TW;
    localparam int unsigned DEPTH = 4;
`ifdef MVAU_WMEM_REG_RD_EN
    localparam int unsigned LAT_EXTRA  = 1;
    localparam int unsigned EN_LO_MAX  = 2;
    localparam int unsigned STALL_ADDR = 2;
`else
    localparam int unsigned LAT_EXTRA  = 0;
    localparam int unsigned EN_LO_MAX  = 1;
    localparam int unsigned STALL_ADDR = 1;
`endif

    logic          clk;
    logic          rst;
    logic          en;
    logic          out_rdy;
    logic [1:0]    wmem_addr;
    logic [DW-1:0] wmem_in;
    logic [DW-1:0] out_wgt;
    logic          out_v;
    logic          out_last;

    logic          wmem_addr1;
    logic [DW-1:0] wmem_in1;
    logic [DW-1:0] out_wgt1;
    logic          out_v1;
    logic          out_last1;

    logic [DW-1:0] mem [DEPTH];

    int total = 0;
    int bad   = 0;
    int n_xfer = 0;
    int exp_idx = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_wgt;
    logic          prev_last;

    mvau_weight_fetch #(.SIMD(SIMD), .TW(TW), .WMEM_DEPTH(4), .WMEM_ADDR_BW(2)) dut (
        .clk(clk), .rst(rst), .en(en), .wmem_addr(wmem_addr), .wmem_in(wmem_in),
        .out_wgt(out_wgt), .out_v(out_v), .out_rdy(out_rdy), .out_last(out_last)
    );

    mvau_weight_fetch #(.SIMD(SIMD), .TW(TW), .WMEM_DEPTH(1), .WMEM_ADDR_BW(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .wmem_addr(wmem_addr1), .wmem_in(wmem_in1),
        .out_wgt(out_wgt1), .out_v(out_v1), .out_rdy(out_rdy), .out_last(out_last1)
    );

    initial begin
        mem[0] = 8'hA0;
        mem[1] = 8'hA1;
        mem[2] = 8'hA2;
        mem[3] = 8'hA3;
    end

    // Weight memory models
`ifdef MVAU_WMEM_REG_RD_EN
    always @(posedge clk) begin
        wmem_in  <= mem[wmem_addr];
        wmem_in1 <= 8'h5C;
    end
`else
    assign wmem_in  = mem[wmem_addr];
    assign wmem_in1 = 8'h5C;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted word must be the next address in cyclic order
    always @(negedge clk) begin
        if (rst) begin
            exp_idx    = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_v", 32'(out_v), 32'd1);
                check("stall_wgt", 32'(out_wgt), 32'(prev_wgt));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_v && out_rdy) begin
                check("xfer_wgt", 32'(out_wgt), 32'(mem[exp_idx]));
                check("xfer_last", 32'(out_last), 32'(exp_idx == DEPTH - 1));
                exp_idx = (exp_idx + 1) % DEPTH;
                n_xfer++;
            end
            prev_stall = out_v && !out_rdy;
            prev_wgt   = out_wgt;
            prev_last  = out_last;
            check("d1_addr", 32'(wmem_addr1), 32'd0);
            if (out_v1) begin
                check("d1_wgt", 32'(out_wgt1), 32'h5C);
                check("d1_last", 32'(out_last1), 32'd1);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] pat;
        int base;
        int extra;
        logic [1:0] saved_addr;
        bit found;

        pat = 40'b1011_0010_1110_0101_0011_1001_0110_1100_0101_1010;
        rst = 1'b1;
        en = 1'b0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_v", 32'(out_v), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_wgt", 32'(out_wgt), 32'd0);
        check("rst_addr", 32'(wmem_addr), 32'd0);

        // Latency and full throughput
        @(posedge clk); #1 en = 1'b1;
        @(negedge clk);
        check("lat_n", 32'(out_v), 32'd0);
        for (int i = 0; i < int'(LAT_EXTRA); i++) begin
            @(negedge clk);
            check("lat_n1", 32'(out_v), 32'd0);
        end
        @(negedge clk);
        check("lat_v", 32'(out_v), 32'd1);
        check("lat_wgt", 32'(out_wgt), 32'hA0);
        repeat (12) begin
            @(negedge clk);
            check("tput_v", 32'(out_v), 32'd1);
        end

        // Backpressure pattern over 40 transfers
        base = n_xfer;
        for (int cyc = 0; cyc < 400 && (n_xfer - base) < 40; cyc++) begin
            @(posedge clk); #1 out_rdy = pat[cyc % 40];
        end
        check("bp_done", 32'((n_xfer - base) >= 40), 32'd1);

        // en dropped after two accepts
        @(posedge clk); #1 en = 1'b0; out_rdy = 1'b1;
        do_reset();
        base = n_xfer;
        en = 1'b1;
        found = 0;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            @(posedge clk); #1;
            if (n_xfer - base >= 2) found = 1;
        end
        check("en_two_acc", 32'(found), 32'd1);
        en = 1'b0;
        base = n_xfer;
        repeat (2) @(posedge clk);
        #1 saved_addr = wmem_addr;
        repeat (3) @(posedge clk);
        #1;
        check("en_lo_addr", 32'(wmem_addr), 32'(saved_addr));
        extra = n_xfer - base;
        check("en_lo_extra", 32'(extra <= int'(EN_LO_MAX)), 32'd1);
        @(negedge clk);
        check("en_lo_v", 32'(out_v), 32'd0);
        @(posedge clk); #1 en = 1'b1;
        repeat (10) @(posedge clk);

        // Reset while holding A2 under backpressure
        #1 en = 1'b0;
        do_reset();
        en = 1'b1;
        found = 0;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            @(negedge clk);
            if (out_v && out_wgt == 8'hA1) found = 1;
        end
        check("find_a1", 32'(found), 32'd1);
        @(posedge clk); #1 out_rdy = 1'b0;
        @(negedge clk);
        check("hold_v", 32'(out_v), 32'd1);
        check("hold_a2", 32'(out_wgt), 32'hA2);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_v", 32'(out_v), 32'd0);
        @(posedge clk); #1 out_rdy = 1'b1;
        found = 0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            if (out_v) begin
                found = 1;
                check("after_rst_a0", 32'(out_wgt), 32'hA0);
            end
        end
        check("after_rst_seen", 32'(found), 32'd1);

        // Long stall with en high, then drain back-to-back
        @(posedge clk); #1 en = 1'b0;
        do_reset();
        out_rdy = 1'b0;
        en = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_addr", 32'(wmem_addr), 32'(STALL_ADDR));
        check("stall_head_v", 32'(out_v), 32'd1);
        check("stall_head", 32'(out_wgt), 32'hA0);
        @(posedge clk); #1 out_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("b2b_v", 32'(out_v), 32'd1);
        end
        repeat (8) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
